// File: rtl/mgt_01_mul_scheduler_if.sv
// Multiplier-side bus of the multiply scheduler: operands and start pulse
// towards the shared Booth multiplier, signed product and valid back.
interface mgt_01_mul_scheduler_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0]   multiplier;
  logic [XLEN-1:0]   multiplicand;
  logic              start;
  logic [2*XLEN-1:0] result;
  logic              valid;

  // Scheduler side
  modport master (
    output multiplier,
    output multiplicand,
    output start,
    input  result,
    input  valid
  );

  // Multiplier datapath side
  modport slave (
    input  multiplier,
    input  multiplicand,
    input  start,
    output result,
    output valid
  );
endinterface

// File: rtl/mgt_01_mul_scheduler.sv
// Shares one signed XLEN x XLEN multiplier between the RV32M integer unit and
// the FPU mantissa path. One operation in flight at a time; round-robin
// arbitration when both requesters are valid; high-word sign correction turns
// the signed product into MULHSU/MULHU results.
module mgt_01_mul_scheduler #(
  parameter int XLEN   = 32,
  parameter int MANT_W = 24
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                clk_en_i,
  // Integer requester
  input  logic                int_req_valid_i,
  output logic                int_req_ready_o,
  input  logic [1:0]          int_op_i,
  input  logic [XLEN-1:0]     int_a_i,
  input  logic [XLEN-1:0]     int_b_i,
  output logic                int_res_valid_o,
  input  logic                int_res_ready_i,
  output logic [XLEN-1:0]     int_res_o,
  // FPU requester
  input  logic                fpu_req_valid_i,
  output logic                fpu_req_ready_o,
  input  logic [MANT_W-1:0]   fpu_mant_a_i,
  input  logic [MANT_W-1:0]   fpu_mant_b_i,
  output logic                fpu_res_valid_o,
  input  logic                fpu_res_ready_i,
  output logic [2*MANT_W-1:0] fpu_res_o,
  // Shared multiplier
  mgt_01_mul_scheduler_if.master mul,
  output logic                busy_o
);

  // Result register is wide enough for either an integer word or a full
  // mantissa product.
  localparam int RES_W = (2 * MANT_W > XLEN) ? 2 * MANT_W : XLEN;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_e;

  typedef enum logic {
    OWN_INT,
    OWN_FPU
  } owner_e;

  typedef enum logic [1:0] {
    OP_MUL,
    OP_MULH,
    OP_MULHSU,
    OP_MULHU
  } op_e;

  state_e            state_q;
  owner_e            owner_q;
  owner_e            last_grant_q;
  op_e               op_q;
  logic [XLEN-1:0]   a_q;
  logic [XLEN-1:0]   b_q;
  logic [RES_W-1:0]  res_q;
  logic              start_q;
  logic              int_vld_q;
  logic              fpu_vld_q;

  logic              grant_int;
  logic              grant_fpu;
  logic              can_accept;
  logic [XLEN-1:0]   prod_hi;
  logic [XLEN-1:0]   prod_lo;
  logic [XLEN-1:0]   int_corr;
  logic [RES_W-1:0]  res_next;

  // Round-robin: on contention the requester that did not win last time wins.
  assign grant_fpu  = fpu_req_valid_i && (!int_req_valid_i || (last_grant_q == OWN_INT));
  assign grant_int  = int_req_valid_i && !grant_fpu;
  assign can_accept = (state_q == S_IDLE) && clk_en_i;

  assign int_req_ready_o = can_accept && grant_int;
  assign fpu_req_ready_o = can_accept && grant_fpu;

  assign prod_hi = mul.result[2*XLEN-1:XLEN];
  assign prod_lo = mul.result[XLEN-1:0];

  // Sign correction of the signed product for the requested result form.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path can
    // leave it unassigned and infer a latch.
    int_corr = prod_lo;
    res_next = '0;
    unique case (op_q)
      OP_MUL:    int_corr = prod_lo;
      OP_MULH:   int_corr = prod_hi;
      OP_MULHSU: int_corr = prod_hi + (b_q[XLEN-1] ? a_q : '0);
      OP_MULHU:  int_corr = prod_hi + (a_q[XLEN-1] ? b_q : '0)
                                    + (b_q[XLEN-1] ? a_q : '0);
      default:   int_corr = prod_lo;
    endcase
    if (owner_q == OWN_FPU) begin
      res_next = RES_W'(mul.result[2*MANT_W-1:0]);
    end else begin
      res_next = RES_W'(int_corr);
    end
  end

  // Control FSM with all datapath registers and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      state_q      <= S_IDLE;
      owner_q      <= OWN_INT;
      last_grant_q <= OWN_FPU;
      op_q         <= OP_MUL;
      a_q          <= '0;
      b_q          <= '0;
      res_q        <= '0;
      start_q      <= 1'b0;
      int_vld_q    <= 1'b0;
      fpu_vld_q    <= 1'b0;
    end else if (clk_en_i) begin
      unique case (state_q)
        S_IDLE: begin
          if (grant_int) begin
            owner_q      <= OWN_INT;
            last_grant_q <= OWN_INT;
            op_q         <= op_e'(int_op_i);
            a_q          <= int_a_i;
            b_q          <= int_b_i;
            start_q      <= 1'b1;
            state_q      <= S_ISSUE;
          end else if (grant_fpu) begin
            owner_q      <= OWN_FPU;
            last_grant_q <= OWN_FPU;
            op_q         <= OP_MUL;
            a_q          <= XLEN'(fpu_mant_a_i);
            b_q          <= XLEN'(fpu_mant_b_i);
            start_q      <= 1'b1;
            state_q      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          start_q <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (mul.valid) begin
            res_q   <= res_next;
            state_q <= S_RESP;
            if (owner_q == OWN_FPU) begin
              fpu_vld_q <= 1'b1;
            end else begin
              int_vld_q <= 1'b1;
            end
          end
        end
        S_RESP: begin
          if ((owner_q == OWN_INT && int_res_ready_i) ||
              (owner_q == OWN_FPU && fpu_res_ready_i)) begin
            int_vld_q <= 1'b0;
            fpu_vld_q <= 1'b0;
            state_q   <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Start is gated so a frozen ISSUE cycle does not look like extra starts.
  assign mul.start        = start_q && clk_en_i;
  assign mul.multiplier   = a_q;
  assign mul.multiplicand = b_q;

  assign int_res_valid_o = int_vld_q;
  assign fpu_res_valid_o = fpu_vld_q;
  assign int_res_o       = res_q[XLEN-1:0];
  assign fpu_res_o       = res_q[2*MANT_W-1:0];
  assign busy_o          = (state_q != S_IDLE);

endmodule

// File: tb/tb_mgt_01_mul_scheduler.sv
// Directed bench for the multiply scheduler: a behavioural signed multiplier
// answers each start pulse after a chosen latency; results are compared with
// hand-computed constants.
module tb_mgt_01_mul_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_en;
  logic        int_req_valid;
  logic        int_req_ready;
  logic [1:0]  int_op;
  logic [31:0] int_a;
  logic [31:0] int_b;
  logic        int_res_valid;
  logic        int_res_ready;
  logic [31:0] int_res;
  logic        fpu_req_valid;
  logic        fpu_req_ready;
  logic [23:0] fpu_mant_a;
  logic [23:0] fpu_mant_b;
  logic        fpu_res_valid;
  logic        fpu_res_ready;
  logic [47:0] fpu_res;
  logic        busy;

  int checks = 0;
  int errors = 0;

  mgt_01_mul_scheduler_if #(.XLEN(32)) mul_bus ();

  mgt_01_mul_scheduler #(.XLEN(32), .MANT_W(24)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .clk_en_i        (clk_en),
    .int_req_valid_i (int_req_valid),
    .int_req_ready_o (int_req_ready),
    .int_op_i        (int_op),
    .int_a_i         (int_a),
    .int_b_i         (int_b),
    .int_res_valid_o (int_res_valid),
    .int_res_ready_i (int_res_ready),
    .int_res_o       (int_res),
    .fpu_req_valid_i (fpu_req_valid),
    .fpu_req_ready_o (fpu_req_ready),
    .fpu_mant_a_i    (fpu_mant_a),
    .fpu_mant_b_i    (fpu_mant_b),
    .fpu_res_valid_o (fpu_res_valid),
    .fpu_res_ready_i (fpu_res_ready),
    .fpu_res_o       (fpu_res),
    .mul             (mul_bus.master),
    .busy_o          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  // Behavioural multiplier: called at the negedge of the ISSUE cycle; pulses
  // valid with the signed product lat cycles later, returns at RESP negedge.
  task automatic mul_respond(input int lat);
    longint sa;
    longint sb;
    sa = longint'($signed(mul_bus.multiplier));
    sb = longint'($signed(mul_bus.multiplicand));
    repeat (lat) @(negedge clk);
    mul_bus.result = 64'(sa * sb);
    mul_bus.valid  = 1'b1;
    @(negedge clk);
    mul_bus.valid  = 1'b0;
    #1;
  endtask

  task automatic int_txn(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat, output logic [31:0] res, output logic vld);
    int n;
    int_op = op; int_a = a; int_b = b; int_req_valid = 1'b1;
    #1;
    n = 0;
    while (!int_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    res = '0; vld = 1'b0;
    if (!int_req_ready) begin
      checks++; errors++;
      $display("FAIL int_accept_timeout ready=%0b required=1", int_req_ready);
      int_req_valid = 1'b0;
    end else begin
      @(negedge clk);
      int_req_valid = 1'b0;
      mul_respond(lat);
      res = int_res; vld = int_res_valid;
      int_res_ready = 1'b1;
      @(negedge clk);
      int_res_ready = 1'b0;
      #1;
    end
  endtask

  task automatic fpu_txn(input logic [23:0] a, input logic [23:0] b, input int lat,
                         output logic [47:0] res, output logic vld, output logic int_seen);
    int n;
    fpu_mant_a = a; fpu_mant_b = b; fpu_req_valid = 1'b1;
    #1;
    n = 0;
    while (!fpu_req_ready && n < 20) begin
      @(negedge clk); #1; n++;
    end
    res = '0; vld = 1'b0; int_seen = 1'b0;
    if (!fpu_req_ready) begin
      checks++; errors++;
      $display("FAIL fpu_accept_timeout ready=%0b required=1", fpu_req_ready);
      fpu_req_valid = 1'b0;
    end else begin
      @(negedge clk);
      fpu_req_valid = 1'b0;
      #1;
      int_seen = int_res_valid;
      mul_respond(lat);
      res = fpu_res; vld = fpu_res_valid;
      int_seen = int_seen | int_res_valid;
      fpu_res_ready = 1'b1;
      @(negedge clk);
      fpu_res_ready = 1'b0;
      #1;
      int_seen = int_seen | int_res_valid;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_en = 1'b1;
    int_req_valid = 1'b0; int_op = 2'd0; int_a = '0; int_b = '0; int_res_ready = 1'b0;
    fpu_req_valid = 1'b0; fpu_mant_a = '0; fpu_mant_b = '0; fpu_res_ready = 1'b0;
    mul_bus.result = '0; mul_bus.valid = 1'b0;
    #1;
    checks++;
    if ({int_req_ready, fpu_req_ready, int_res_valid, fpu_res_valid, mul_bus.start, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b required=000000",
               {int_req_ready, fpu_req_ready, int_res_valid, fpu_res_valid, mul_bus.start, busy});
    end
    checks++;
    if ({int_res, fpu_res, mul_bus.multiplier, mul_bus.multiplicand} !== 144'b0) begin
      errors++;
      $display("FAIL reset_data int_res=%h fpu_res=%h a=%h b=%h required=0",
               int_res, fpu_res, mul_bus.multiplier, mul_bus.multiplicand);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_mul_basic();
    int starts;
    int_op = 2'd0; int_a = 32'd7; int_b = 32'hFFFF_FFFD; int_req_valid = 1'b1;
    #1;
    checks++;
    if ({int_req_ready, fpu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL basic_ready got=%b required=10", {int_req_ready, fpu_req_ready});
    end
    @(negedge clk);
    int_req_valid = 1'b0;
    #1;
    starts = int'(mul_bus.start);
    checks++;
    if (mul_bus.multiplier !== 32'd7 || mul_bus.multiplicand !== 32'hFFFF_FFFD || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_issue a=%h b=%h busy=%b required 00000007 fffffffd 1",
               mul_bus.multiplier, mul_bus.multiplicand, busy);
    end
    repeat (3) begin
      @(negedge clk); #1;
      starts += int'(mul_bus.start);
    end
    checks++;
    if (int_res_valid !== 1'b0) begin
      errors++; $display("FAIL basic_early_valid got=%b required=0", int_res_valid);
    end
    mul_bus.result = 64'hFFFF_FFFF_FFFF_FFEB; mul_bus.valid = 1'b1;
    @(negedge clk);
    mul_bus.valid = 1'b0;
    #1;
    checks++;
    if (starts !== 1) begin
      errors++; $display("FAIL basic_start_pulses got=%0d required=1", starts);
    end
    checks++;
    if (int_res_valid !== 1'b1 || int_res !== 32'hFFFF_FFEB || fpu_res_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_result valid=%b res=%h fpu_valid=%b required 1 ffffffeb 0",
               int_res_valid, int_res, fpu_res_valid);
    end
    int_res_ready = 1'b1;
    @(negedge clk);
    int_res_ready = 1'b0;
    #1;
    checks++;
    if (int_res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL basic_release valid=%b busy=%b required 0 0", int_res_valid, busy);
    end
  endtask

  task automatic test_sign_correction();
    logic [1:0]  ops  [3] = '{2'd1, 2'd3, 2'd2};
    logic [31:0] va   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vb   [3] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] vexp [3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    logic [31:0] res;
    logic        vld;
    for (int i = 0; i < 3; i++) begin
      int_txn(ops[i], va[i], vb[i], 2 + i, res, vld);
      checks++;
      if (vld !== 1'b1 || res !== vexp[i]) begin
        errors++;
        $display("FAIL sign_op%0d valid=%b res=%h required 1 %h", ops[i], vld, res, vexp[i]);
      end
    end
  endtask

  task automatic test_fpu();
    logic [23:0] ma   [2] = '{24'h80_0000, 24'hFF_FFFF};
    logic [47:0] vexp [2] = '{48'h4000_0000_0000, 48'hFFFF_FE00_0001};
    logic [47:0] res;
    logic        vld;
    logic        int_seen;
    for (int i = 0; i < 2; i++) begin
      fpu_txn(ma[i], ma[i], 3, res, vld, int_seen);
      checks++;
      if (vld !== 1'b1 || res !== vexp[i] || int_seen !== 1'b0) begin
        errors++;
        $display("FAIL fpu_%0d valid=%b res=%h int_valid_seen=%b required 1 %h 0",
                 i, vld, res, int_seen, vexp[i]);
      end
    end
  endtask

  task automatic test_arbitration();
    int n;
    logic got_fpu;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    int_op = 2'd0; int_a = 32'd3; int_b = 32'd5;
    fpu_mant_a = 24'd2; fpu_mant_b = 24'd3;
    int_req_valid = 1'b1; fpu_req_valid = 1'b1;
    int_res_ready = 1'b1; fpu_res_ready = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      n = 0;
      while (!(int_req_ready || fpu_req_ready) && n < 20) begin
        @(negedge clk); #1; n++;
      end
      checks++;
      if (int_req_ready && fpu_req_ready) begin
        errors++; $display("FAIL arb_both_ready grant%0d got=11 required one-hot", g);
      end
      got_fpu = fpu_req_ready;
      checks++;
      if (!(int_req_ready || fpu_req_ready) || got_fpu !== logic'(g % 2)) begin
        errors++;
        $display("FAIL arb_order grant%0d got int=%b fpu=%b required fpu=%0d",
                 g, int_req_ready, fpu_req_ready, g % 2);
      end
      @(negedge clk); #1;
      checks++;
      if (busy !== 1'b1) begin
        errors++; $display("FAIL arb_busy_issue grant%0d got=%b required=1", g, busy);
      end
      mul_respond(1);
      checks++;
      if (busy !== 1'b1 || (got_fpu ? (fpu_res !== 48'd6 || fpu_res_valid !== 1'b1)
                                    : (int_res !== 32'd15 || int_res_valid !== 1'b1))) begin
        errors++;
        $display("FAIL arb_result grant%0d busy=%b int=%h fpu=%h required busy=1 int=f or fpu=6",
                 g, busy, int_res, fpu_res);
      end
      @(negedge clk); #1;
    end
    int_req_valid = 1'b0; fpu_req_valid = 1'b0;
    int_res_ready = 1'b0; fpu_res_ready = 1'b0;
    #1;
  endtask

  task automatic test_backpressure();
    int_op = 2'd0; int_a = 32'h1234; int_b = 32'h10; int_req_valid = 1'b1;
    #1;
    checks++;
    if (int_req_ready !== 1'b1) begin
      errors++; $display("FAIL bp_accept got=%b required=1", int_req_ready);
    end
    @(negedge clk);
    int_req_valid = 1'b0;
    fpu_mant_a = 24'd1; fpu_mant_b = 24'd1; fpu_req_valid = 1'b1;
    mul_respond(2);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (int_res_valid !== 1'b1 || int_res !== 32'h0001_2340 || fpu_req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle%0d valid=%b res=%h fpu_ready=%b required 1 00012340 0",
                 i, int_res_valid, int_res, fpu_req_ready);
      end
      @(negedge clk); #1;
    end
    int_res_ready = 1'b1;
    @(negedge clk);
    int_res_ready = 1'b0;
    #1;
    checks++;
    if (int_res_valid !== 1'b0 || fpu_req_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release valid=%b fpu_ready=%b required 0 1", int_res_valid, fpu_req_ready);
    end
    fpu_req_valid = 1'b0;
    #1;
  endtask

  task automatic test_clk_enable();
    clk_en = 1'b0;
    int_op = 2'd1; int_a = 32'h8000_0000; int_b = 32'h8000_0000; int_req_valid = 1'b1;
    #1;
    checks++;
    if (int_req_ready !== 1'b0) begin
      errors++; $display("FAIL en_ready_frozen got=%b required=0", int_req_ready);
    end
    @(negedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL en_no_accept busy=%b required=0", busy);
    end
    clk_en = 1'b1;
    #1;
    @(negedge clk);
    int_req_valid = 1'b0;
    clk_en = 1'b0;
    #1;
    checks++;
    if (mul_bus.start !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL en_start_gated start=%b busy=%b required 0 1", mul_bus.start, busy);
    end
    @(negedge clk);
    clk_en = 1'b1;
    #1;
    checks++;
    if (mul_bus.start !== 1'b1) begin
      errors++; $display("FAIL en_start_resume got=%b required=1", mul_bus.start);
    end
    @(negedge clk);
    clk_en = 1'b0;
    mul_bus.result = 64'h4000_0000_0000_0000; mul_bus.valid = 1'b1;
    @(negedge clk);
    mul_bus.valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (int_res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL en_frozen_wait valid=%b busy=%b required 0 1", int_res_valid, busy);
    end
    clk_en = 1'b1;
    @(negedge clk); #1;
    checks++;
    if (int_res_valid !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL en_pulse_ignored valid=%b busy=%b required 0 1", int_res_valid, busy);
    end
    mul_bus.valid = 1'b1;
    @(negedge clk);
    mul_bus.valid = 1'b0;
    #1;
    checks++;
    if (int_res_valid !== 1'b1 || int_res !== 32'h4000_0000) begin
      errors++;
      $display("FAIL en_result valid=%b res=%h required 1 40000000", int_res_valid, int_res);
    end
    int_res_ready = 1'b1;
    @(negedge clk);
    int_res_ready = 1'b0;
    #1;
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    logic        vld;
    int_op = 2'd0; int_a = 32'd7; int_b = 32'hFFFF_FFFD; int_req_valid = 1'b1;
    #1;
    @(negedge clk);
    int_req_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, mul_bus.start, int_res_valid, int_req_ready} !== 4'b0 ||
        mul_bus.multiplier !== 32'd0 || int_res !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs busy=%b start=%b valid=%b a=%h res=%h required all 0",
               busy, mul_bus.start, int_res_valid, mul_bus.multiplier, int_res);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mul_bus.result = 64'hFFFF_FFFF_FFFF_FFEB; mul_bus.valid = 1'b1;
    @(negedge clk);
    mul_bus.valid = 1'b0;
    #1;
    checks++;
    if (int_res_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_late_valid valid=%b busy=%b required 0 0", int_res_valid, busy);
    end
    int_txn(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4, res, vld);
    checks++;
    if (vld !== 1'b1 || res !== 32'hFFFF_FFFE) begin
      errors++; $display("FAIL rst_next_txn valid=%b res=%h required 1 fffffffe", vld, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_sign_correction();
    test_fpu();
    test_arbitration();
    test_backpressure();
    test_clk_enable();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
